// File: rtl/button_input_pkg.sv
// Shared definitions for the operator-entry button block (package xdn_defs):
// default bus width, button active level and FSM state encodings.
package xdn_defs;
  localparam int unsigned DEF_DATA_WIDTH = 8;
  localparam logic        BTN_PRESSED    = 1'b0;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

  typedef enum logic [1:0] {
    REP_NONE = 2'd0,
    REP_INC  = 2'd1,
    REP_DEC  = 2'd2
  } rep_sel_t;
endpackage

// File: rtl/button_input_debouncer.sv
// Per-button conditioning: 2-flop synchronizer, debounce counter, press pulse.
// o_press is high for the cycle whose rising edge flips o_level to pressed.
module button_debouncer
  import xdn_defs::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 32'hFFFFF
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_raw,
  output logic o_level,
  output logic o_press
);

  logic        r_sync1;
  logic        r_sync2;
  logic        r_level;
  logic [31:0] r_cnt;
  logic        w_settled;

  assign w_settled = (r_sync2 != r_level) && (r_cnt == DEBOUNCE_CYCLES - 1);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync1 <= ~BTN_PRESSED;
      r_sync2 <= ~BTN_PRESSED;
      r_level <= ~BTN_PRESSED;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= i_raw;
      r_sync2 <= r_sync1;
      if (r_sync2 == r_level) begin
        r_cnt <= '0;
      end else if (w_settled) begin
        r_level <= r_sync2;
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + 32'd1;
      end
    end
  end

  assign o_level = r_level;
  assign o_press = w_settled && (r_sync2 == BTN_PRESSED);

endmodule

// File: rtl/button_input.sv
// Operator entry: INC/DEC edit a value, COMMIT latches it for the CPU bus.
// Optional auto-repeat on INC/DEC when BUTTON_INPUT_AUTOREPEAT_EN is defined.
module button_input
  import xdn_defs::*;
#(
  parameter int unsigned DATA_WIDTH      = DEF_DATA_WIDTH,
  parameter int unsigned DEBOUNCE_CYCLES = 32'hFFFFF,
  parameter int unsigned REPEAT_DELAY    = 32'h7FFFFF,
  parameter int unsigned REPEAT_PERIOD   = 32'h1FFFFF
) (
  input  logic                  i_SYS_CLOCK,
  input  logic                  i_CLEAR_n,
  input  logic                  i_BTN_INC,
  input  logic                  i_BTN_DEC,
  input  logic                  i_BTN_COMMIT,
  input  logic                  i_WRITE_BUS_n,
  output logic [DATA_WIDTH-1:0] BUS,
  output logic [DATA_WIDTH-1:0] o_EDIT_VALUE,
  output logic                  o_READY,
  output logic                  o_OVERRUN
);

  logic                  w_inc_press;
  logic                  w_dec_press;
  logic                  w_commit;
  logic                  w_inc_evt;
  logic                  w_dec_evt;
  logic [DATA_WIDTH-1:0] r_edit;
  logic [DATA_WIDTH-1:0] r_hold;
  logic                  r_overrun;
  state_t                r_state;

`ifdef BUTTON_INPUT_AUTOREPEAT_EN
  logic                  w_inc_level;
  logic                  w_dec_level;
`endif

  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_inc (
    .i_clk   (i_SYS_CLOCK),
    .i_rst_n (i_CLEAR_n),
    .i_raw   (i_BTN_INC),
`ifdef BUTTON_INPUT_AUTOREPEAT_EN
    .o_level (w_inc_level),
`else
    .o_level (),
`endif
    .o_press (w_inc_press)
  );

  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_dec (
    .i_clk   (i_SYS_CLOCK),
    .i_rst_n (i_CLEAR_n),
    .i_raw   (i_BTN_DEC),
`ifdef BUTTON_INPUT_AUTOREPEAT_EN
    .o_level (w_dec_level),
`else
    .o_level (),
`endif
    .o_press (w_dec_press)
  );

  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_commit (
    .i_clk   (i_SYS_CLOCK),
    .i_rst_n (i_CLEAR_n),
    .i_raw   (i_BTN_COMMIT),
    .o_level (),
    .o_press (w_commit)
  );

`ifdef BUTTON_INPUT_AUTOREPEAT_EN
  rep_sel_t    r_rep_sel;
  logic        r_rep_armed;
  logic [31:0] r_rep_cnt;
  logic        w_rep_held;
  logic        w_rep_fire;

  assign w_rep_held = ((r_rep_sel == REP_INC) && (w_inc_level == BTN_PRESSED)) ||
                      ((r_rep_sel == REP_DEC) && (w_dec_level == BTN_PRESSED));
  assign w_rep_fire = w_rep_held &&
                      (r_rep_cnt == (r_rep_armed ? REPEAT_PERIOD - 1 : REPEAT_DELAY - 1));

  // A fresh press always restarts the delay; simultaneous presses cancel out.
  always_ff @(posedge i_SYS_CLOCK or negedge i_CLEAR_n) begin
    if (!i_CLEAR_n) begin
      r_rep_sel   <= REP_NONE;
      r_rep_armed <= 1'b0;
      r_rep_cnt   <= '0;
    end else if (w_inc_press || w_dec_press) begin
      r_rep_sel   <= (w_inc_press && w_dec_press) ? REP_NONE :
                     (w_inc_press ? REP_INC : REP_DEC);
      r_rep_armed <= 1'b0;
      r_rep_cnt   <= '0;
    end else if (!w_rep_held) begin
      r_rep_sel   <= REP_NONE;
      r_rep_armed <= 1'b0;
      r_rep_cnt   <= '0;
    end else if (w_rep_fire) begin
      r_rep_armed <= 1'b1;
      r_rep_cnt   <= '0;
    end else begin
      r_rep_cnt   <= r_rep_cnt + 32'd1;
    end
  end

  assign w_inc_evt = w_inc_press || (w_rep_fire && (r_rep_sel == REP_INC));
  assign w_dec_evt = w_dec_press || (w_rep_fire && (r_rep_sel == REP_DEC));
`else
  assign w_inc_evt = w_inc_press;
  assign w_dec_evt = w_dec_press;
`endif

  always_ff @(posedge i_SYS_CLOCK or negedge i_CLEAR_n) begin
    if (!i_CLEAR_n) begin
      r_edit    <= '0;
      r_hold    <= '0;
      r_overrun <= 1'b0;
      r_state   <= ST_EMPTY;
    end else begin
      if (w_inc_evt && !w_dec_evt) begin
        r_edit <= r_edit + DATA_WIDTH'(1);
      end else if (w_dec_evt && !w_inc_evt) begin
        r_edit <= r_edit - DATA_WIDTH'(1);
      end
      case (r_state)
        ST_EMPTY: begin
          if (w_commit) begin
            r_hold  <= r_edit;
            r_state <= ST_FULL;
          end
        end
        ST_FULL: begin
          // Commit beats a concurrent read; only an unread overwrite is an overrun.
          if (w_commit) begin
            r_hold <= r_edit;
            if (i_WRITE_BUS_n) begin
              r_overrun <= 1'b1;
            end
          end else if (!i_WRITE_BUS_n) begin
            r_state <= ST_EMPTY;
          end
        end
        default: r_state <= ST_EMPTY;
      endcase
    end
  end

  assign o_EDIT_VALUE = r_edit;
  assign o_READY      = (r_state == ST_FULL);
  assign o_OVERRUN    = r_overrun;
  assign BUS          = i_WRITE_BUS_n ? 'z : r_hold;

endmodule
